// File: rtl/ipml_prefetch_sync_fifo_v2.sv
// Single-clock first-word-fall-through FIFO: register array plus one-entry prefetch
// output register, with occupancy level, almost-full/almost-empty flags and flush.
module ipml_prefetch_sync_fifo_v2 #(
  parameter int W     = 16,
  parameter int AW    = 4,
  parameter int AF_TH = (1 << AW),
  parameter int AE_TH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_L  = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_L  = (AW+1)'(AE_TH);

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          accept;
  logic          pop;
  logic          load;

  assign in_ready     = (count != DEPTH);
  assign accept       = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign load         = (count != '0) & (~out_valid | pop);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // Storage is deliberately left out of reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      // out_data is intentionally kept; only the bookkeeping is cleared.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, load};
      level <= level + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end
  end

endmodule
